scm_mc: RTL
===========

Name: scm_mc

Overview:
- Parametrised multi-channel successor to the single-protocol statistics module.
- Sits in the MD/PHV pipeline between gme and the next stage, and on the control-packet chain.
- Forwards every MD/PHV pair, rewriting the module-ID field of pairs addressed to LMID.
- Keeps per-channel packet and byte counters with independent protocol filters, plus an end-of-test window; counters are readable and configurable via 134-bit control packets.

Parameters:
- MD_W, 256, metadata width (at least 108)
- PHV_W, 1024, PHV width
- FIFO_AW, 8, MD/PHV FIFO address width; depth = 2^FIFO_AW
- NCH, 4, number of counter channels (1..16)
- LMID, 8'd7, local module ID matched in MD[87:80]
- NMID, 8'd4, next module ID written into MD[87:80]
- AF_MARGIN, 6, almost-full asserts when usedw > depth-AF_MARGIN

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_scm_md / in_scm_md_wr  in  MD_W / 1  metadata input
- out_scm_md_alf  out  1  = in_scm_md_alf OR MD usedw > depth-AF_MARGIN
- in_scm_phv / in_scm_phv_wr  in  PHV_W / 1  PHV input
- out_scm_phv_alf  out  1  same rule on the PHV FIFO
- out_scm_md / out_scm_md_wr  out  MD_W / 1  metadata output
- in_scm_md_alf  in  1  downstream MD almost-full
- out_scm_phv / out_scm_phv_wr  out  PHV_W / 1  PHV output
- in_scm_phv_alf  in  1  downstream PHV almost-full
- gac2scm_sent_start / gac2scm_sent_end  in  1 / 1  test start / end pulses
- cin_scm_data / cin_scm_data_wr  in  134 / 1  control packets in
- cout_scm_ready  out  1  = cin_scm_ready
- cout_scm_data / cout_scm_data_wr  out  134 / 1  control packets out
- cin_scm_ready  in  1  downstream ready

Behaviour:
- Reset: rst_n asynchronous, active-low; clk rising edge. All outputs, counters, config, FIFOs and state clear to 0; state IDLE; n_rtt = 0; all channel enables 0.
- Datapath:
  - Show-ahead MD and PHV FIFOs.
  - Pop both in the same cycle iff both are non-empty AND NOT (in_scm_md_alf OR in_scm_phv_alf).
  - Outputs are registered; wr pulses the cycle after the pop; wr is 0 when there is no pop.
  - If MD[87:80] == LMID, output MD[87:80] = NMID; otherwise the pair passes unmodified.
  - Data and order are never dropped, in every state.
- Counting (on a popped pair with MD[87:80] == LMID, while in RUN or TAIL):
  - Per channel k: if en[k] and MD[79:72] == proto[k], then pkt[k] += 1 and byte[k] += MD[107:96] (zero-extended).
  - Counters are 64-bit and wrap mod 2^64.
  - Several channels may match the same pair.
- FSM:
  - IDLE: start -> RUN.
  - RUN: end -> TAIL, with tail_cnt = 0.
  - TAIL: each counted local pair increments tail_cnt; when tail_cnt == n_rtt after the increment, or immediately if n_rtt == 0, -> HOLD.
  - HOLD: counters frozen; forwarding continues.
  - Start and end in the same cycle in IDLE: start wins, end ignored. Start in RUN, TAIL or HOLD is ignored.
  - Soft reset -> IDLE: clears counters, tail_cnt and shadow registers; config is kept.
- Control packets:
  - Field layout: [133:132] 01 = head, 10 = tail; [126:124] op, 010 = write, 001 = read; [111:104] source MID; [103:96] destination MID; [95:64] address; [31:0] data.
  - Only head flits with destination == LMID are decoded.
  - Write map:
    - 0x7000_0001: bit0 = 1 issues a one-cycle soft reset.
    - 0x7000_0002: n_rtt[31:0].
    - 0x7000_0010+k: proto[k] = [7:0], en[k] = [8].
  - A write head and its tail are consumed; cout_scm_data_wr stays 0 for both.
  - Read: response is {in[133:128], 4'b1011, in[123:112], in[103:96], in[111:104], in[95:32], rdata}, 1-cycle latency.
  - Read map:
    - 0x7000_0002: n_rtt.
    - 0x7000_0003: {30'b0, state}.
    - 0x7000_0010+k: {23'b0, en, proto}.
    - 0x7000_0100 + 4k + i: i = 0 byte lo, 1 byte hi, 2 pkt lo, 3 pkt hi.
    - Unmapped, or k >= NCH: 0xFFFF_FFFF.
  - Coherent reads: reading a lo word latches the matching hi word into a shadow register; the next hi read of the same counter returns the shadow.
  - All other flits are forwarded with 1-cycle latency, including the tail following a read.
  - A packet arriving while cin_scm_ready = 0 is the sender's responsibility (ready is a pass-through).

Decomposition:
- Package scm_pkg: FSM state enum; control field offsets; op codes; address constants; response type 4'b1011.
- Sub-module scm_ch_cnt, one instance per channel: protocol compare plus 64-bit pkt/byte counters, clear and freeze inputs.
- Instantiate the existing FIFO IP, sized by parameters.

Test Plan:
- Bypass: 3 pairs with MD[87:80] = 8'd9 in IDLE -> output identical, 3 wr pulses, all counters 0.
- Count:
  - Configure ch0 = {en, 0x01} and ch1 = {en, 0x02}; pulse start.
  - Send 5 local pairs with proto 0x01 and len 100, and 2 with proto 0x02 and len 60.
  - Expect pkt0 = 5, byte0 = 500, pkt1 = 2, byte1 = 120; output MD[87:80] = 4.
- Window:
  - Set n_rtt = 3; pulse start, then end; send 6 matching local pairs.
  - Expect pkt = 3, state reads 3 (HOLD), and all 6 pairs are forwarded.
- Backpressure: hold in_scm_md_alf = 1 with 10 queued pairs -> no wr; release -> 10 wr in order, no loss.
- Coherent read: preload byte0 = 0x0000_0001_FFFF_FFFF, read lo, send 1 counted pair of len 1, read hi -> returns 0x1.
- Control: write to destination 8'd5 -> forwarded unchanged; read unmapped 0x7000_0200 -> data 0xFFFF_FFFF, type 4'b1011, MIDs swapped.

Source files
------------

// File: rtl/scm_pkg.sv
// Shared types and constants for the multi-channel statistics module.
package scm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_TAIL = 2'd2,
        ST_HOLD = 2'd3
    } scm_st_e;

    localparam int MD_MID_LO   = 80;
    localparam int MD_PROTO_LO = 72;
    localparam int MD_LEN_LO   = 96;

    localparam int CP_W = 134;

    localparam logic [1:0] FL_HEAD = 2'b01;
    localparam logic [1:0] FL_TAIL = 2'b10;

    localparam logic [2:0] OP_WR = 3'b010;
    localparam logic [2:0] OP_RD = 3'b001;

    localparam logic [3:0] RSP_TYPE = 4'b1011;

    localparam logic [31:0] A_SRST  = 32'h7000_0001;
    localparam logic [31:0] A_NRTT  = 32'h7000_0002;
    localparam logic [31:0] A_STATE = 32'h7000_0003;
    // Upper address bits of the per-channel config and counter windows.
    localparam logic [27:0] A_CFG_HI = 28'h700_0001;
    localparam logic [25:0] A_CNT_HI = 26'h1C0_0004;

endpackage

// File: rtl/scm_ch_cnt.sv
// One counter channel: protocol filter plus 64-bit packet and byte counters.
module scm_ch_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_clr,
    input  logic        i_frz,
    input  logic        i_vld,
    input  logic        i_en,
    input  logic [7:0]  i_cfg_proto,
    input  logic [7:0]  i_pkt_proto,
    input  logic [11:0] i_len,
    output logic [63:0] o_pkt,
    output logic [63:0] o_byte
);

    logic w_hit;

    assign w_hit = i_vld && !i_frz && i_en && (i_pkt_proto == i_cfg_proto);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_pkt  <= '0;
            o_byte <= '0;
        end else if (i_clr) begin
            o_pkt  <= '0;
            o_byte <= '0;
        end else if (w_hit) begin
            o_pkt  <= o_pkt + 64'd1;
            o_byte <= o_byte + {52'd0, i_len};
        end
    end

endmodule

// File: rtl/scm_fifo.sv
// Show-ahead synchronous FIFO; head word is visible while not empty.
module scm_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_wr,
    input  logic [W-1:0] i_data,
    input  logic         i_rd,
    output logic [W-1:0] o_data,
    output logic         o_empty,
    output logic [AW:0]  o_usedw
);

    logic [W-1:0] r_mem [1<<AW];
    logic [AW:0]  r_wp;
    logic [AW:0]  r_rp;
    logic         w_full;

    assign o_usedw = r_wp - r_rp;
    assign o_empty = (o_usedw == '0);
    assign w_full  = o_usedw[AW];
    assign o_data  = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge clk) begin
        if (i_wr && !w_full) r_mem[r_wp[AW-1:0]] <= i_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (i_wr && !w_full) r_wp <= r_wp + 1'b1;
            if (i_rd && !o_empty) r_rp <= r_rp + 1'b1;
        end
    end

endmodule

// File: rtl/scm_mc.sv
// MD/PHV forwarder with module-ID rewrite, per-channel protocol statistics
// and an end-of-test window, configured over the control-packet chain.
module scm_mc
    import scm_pkg::*;
#(
    parameter int         MD_W      = 256,
    parameter int         PHV_W     = 1024,
    parameter int         FIFO_AW   = 8,
    parameter int         NCH       = 4,
    parameter logic [7:0] LMID      = 8'd7,
    parameter logic [7:0] NMID      = 8'd4,
    parameter int         AF_MARGIN = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [MD_W-1:0]  in_scm_md,
    input  logic             in_scm_md_wr,
    output logic             out_scm_md_alf,
    input  logic [PHV_W-1:0] in_scm_phv,
    input  logic             in_scm_phv_wr,
    output logic             out_scm_phv_alf,
    output logic [MD_W-1:0]  out_scm_md,
    output logic             out_scm_md_wr,
    input  logic             in_scm_md_alf,
    output logic [PHV_W-1:0] out_scm_phv,
    output logic             out_scm_phv_wr,
    input  logic             in_scm_phv_alf,
    input  logic             gac2scm_sent_start,
    input  logic             gac2scm_sent_end,
    input  logic [133:0]     cin_scm_data,
    input  logic             cin_scm_data_wr,
    output logic             cout_scm_ready,
    output logic [133:0]     cout_scm_data,
    output logic             cout_scm_data_wr,
    input  logic             cin_scm_ready
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] AF_TH = (FIFO_AW+1)'(DEPTH - AF_MARGIN);

    logic [MD_W-1:0]  w_md_q;
    logic [MD_W-1:0]  w_md_fwd;
    logic [PHV_W-1:0] w_phv_q;
    logic             w_md_empty;
    logic             w_phv_empty;
    logic [FIFO_AW:0] w_md_used;
    logic [FIFO_AW:0] w_phv_used;
    logic             w_pop;
    logic             w_local;
    logic             w_frz;
    logic             w_cnt;

    scm_st_e          r_state;
    scm_st_e          w_nxt;
    logic [31:0]      r_nrtt;
    logic [31:0]      r_tail;
    logic             r_srst;
    logic             r_skip;
    logic [NCH-1:0]   r_en;
    logic [7:0]       r_proto [NCH];
    logic [31:0]      r_shb   [NCH];
    logic [31:0]      r_shp   [NCH];
    logic [NCH-1:0]   r_shb_v;
    logic [NCH-1:0]   r_shp_v;
    logic [63:0]      w_pkt   [NCH];
    logic [63:0]      w_byte  [NCH];

    logic [1:0]       w_typ;
    logic [2:0]       w_op;
    logic [7:0]       w_dst;
    logic [31:0]      w_addr;
    logic [31:0]      w_wdat;
    logic             w_is_wr;
    logic             w_is_rd;
    logic             w_cfg_hit;
    logic             w_cnt_hit;
    logic [31:0]      w_rdata;
    logic [133:0]     w_rsp;

    scm_fifo #(.W(MD_W), .AW(FIFO_AW)) u_md_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr    (in_scm_md_wr),
        .i_data  (in_scm_md),
        .i_rd    (w_pop),
        .o_data  (w_md_q),
        .o_empty (w_md_empty),
        .o_usedw (w_md_used)
    );

    scm_fifo #(.W(PHV_W), .AW(FIFO_AW)) u_phv_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr    (in_scm_phv_wr),
        .i_data  (in_scm_phv),
        .i_rd    (w_pop),
        .o_data  (w_phv_q),
        .o_empty (w_phv_empty),
        .o_usedw (w_phv_used)
    );

    assign out_scm_md_alf  = in_scm_md_alf  || (w_md_used  > AF_TH);
    assign out_scm_phv_alf = in_scm_phv_alf || (w_phv_used > AF_TH);
    assign cout_scm_ready  = cin_scm_ready;

    assign w_pop   = !w_md_empty && !w_phv_empty && !(in_scm_md_alf || in_scm_phv_alf);
    assign w_local = (w_md_q[MD_MID_LO+:8] == LMID);
    assign w_frz   = !(r_state == ST_RUN || r_state == ST_TAIL);
    assign w_cnt   = w_pop && w_local && !w_frz;

    always_comb begin
        w_md_fwd = w_md_q;
        if (w_local) w_md_fwd[MD_MID_LO+:8] = NMID;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_scm_md     <= '0;
            out_scm_phv    <= '0;
            out_scm_md_wr  <= 1'b0;
            out_scm_phv_wr <= 1'b0;
        end else begin
            out_scm_md_wr  <= w_pop;
            out_scm_phv_wr <= w_pop;
            if (w_pop) begin
                out_scm_md  <= w_md_fwd;
                out_scm_phv <= w_phv_q;
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        scm_ch_cnt u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_clr       (r_srst),
            .i_frz       (w_frz),
            .i_vld       (w_pop && w_local),
            .i_en        (r_en[g]),
            .i_cfg_proto (r_proto[g]),
            .i_pkt_proto (w_md_q[MD_PROTO_LO+:8]),
            .i_len       (w_md_q[MD_LEN_LO+:12]),
            .o_pkt       (w_pkt[g]),
            .o_byte      (w_byte[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_nxt;
    end

    always_comb begin
        w_nxt = r_state;
        if (r_srst) begin
            w_nxt = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: if (gac2scm_sent_start) w_nxt = ST_RUN;
                ST_RUN:  if (gac2scm_sent_end) w_nxt = ST_TAIL;
                ST_TAIL: begin
                    if (r_nrtt == '0) w_nxt = ST_HOLD;
                    else if (w_cnt && (r_tail + 32'd1 == r_nrtt)) w_nxt = ST_HOLD;
                end
                ST_HOLD: w_nxt = ST_HOLD;
                default: w_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                    r_tail <= '0;
        else if (r_srst)                               r_tail <= '0;
        else if (r_state == ST_RUN && gac2scm_sent_end) r_tail <= '0;
        else if (r_state == ST_TAIL && w_cnt)          r_tail <= r_tail + 32'd1;
    end

    assign w_typ     = cin_scm_data[133:132];
    assign w_op      = cin_scm_data[126:124];
    assign w_dst     = cin_scm_data[103:96];
    assign w_addr    = cin_scm_data[95:64];
    assign w_wdat    = cin_scm_data[31:0];
    assign w_is_wr   = (w_typ == FL_HEAD) && (w_dst == LMID) && (w_op == OP_WR);
    assign w_is_rd   = (w_typ == FL_HEAD) && (w_dst == LMID) && (w_op == OP_RD);
    assign w_cfg_hit = (w_addr[31:4] == A_CFG_HI);
    assign w_cnt_hit = (w_addr[31:6] == A_CNT_HI);

    always_comb begin
        w_rdata = '1;
        if (w_addr == A_NRTT) begin
            w_rdata = r_nrtt;
        end else if (w_addr == A_STATE) begin
            w_rdata = {30'd0, r_state};
        end else if (w_cfg_hit) begin
            for (int k = 0; k < NCH; k++)
                if (w_addr[3:0] == 4'(k)) w_rdata = {23'd0, r_en[k], r_proto[k]};
        end else if (w_cnt_hit) begin
            for (int k = 0; k < NCH; k++) begin
                if (w_addr[5:2] == 4'(k)) begin
                    case (w_addr[1:0])
                        2'd0: w_rdata = w_byte[k][31:0];
                        2'd1: w_rdata = r_shb_v[k] ? r_shb[k] : w_byte[k][63:32];
                        2'd2: w_rdata = w_pkt[k][31:0];
                        default: w_rdata = r_shp_v[k] ? r_shp[k] : w_pkt[k][63:32];
                    endcase
                end
            end
        end
    end

    assign w_rsp = {cin_scm_data[133:128], RSP_TYPE, cin_scm_data[123:112],
                    cin_scm_data[103:96], cin_scm_data[111:104],
                    cin_scm_data[95:32], w_rdata};

    // r_skip swallows the flits of a consumed write up to its tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout_scm_data    <= '0;
            cout_scm_data_wr <= 1'b0;
            r_skip           <= 1'b0;
            r_srst           <= 1'b0;
            r_nrtt           <= '0;
            r_en             <= '0;
            r_shb_v          <= '0;
            r_shp_v          <= '0;
            for (int k = 0; k < NCH; k++) begin
                r_proto[k] <= '0;
                r_shb[k]   <= '0;
                r_shp[k]   <= '0;
            end
        end else begin
            cout_scm_data_wr <= 1'b0;
            r_srst           <= 1'b0;
            if (r_srst) begin
                r_shb_v <= '0;
                r_shp_v <= '0;
                for (int k = 0; k < NCH; k++) begin
                    r_shb[k] <= '0;
                    r_shp[k] <= '0;
                end
            end
            if (cin_scm_data_wr) begin
                if (r_skip) begin
                    if (w_typ == FL_TAIL) r_skip <= 1'b0;
                end else if (w_is_wr) begin
                    r_skip <= 1'b1;
                    if (w_addr == A_SRST) r_srst <= w_wdat[0];
                    if (w_addr == A_NRTT) r_nrtt <= w_wdat;
                    for (int k = 0; k < NCH; k++) begin
                        if (w_cfg_hit && w_addr[3:0] == 4'(k)) begin
                            r_proto[k] <= w_wdat[7:0];
                            r_en[k]    <= w_wdat[8];
                        end
                    end
                end else if (w_is_rd) begin
                    cout_scm_data    <= w_rsp;
                    cout_scm_data_wr <= 1'b1;
                    for (int k = 0; k < NCH; k++) begin
                        if (w_cnt_hit && w_addr[5:2] == 4'(k)) begin
                            case (w_addr[1:0])
                                2'd0: begin
                                    r_shb[k]   <= w_byte[k][63:32];
                                    r_shb_v[k] <= 1'b1;
                                end
                                2'd1: r_shb_v[k] <= 1'b0;
                                2'd2: begin
                                    r_shp[k]   <= w_pkt[k][63:32];
                                    r_shp_v[k] <= 1'b1;
                                end
                                default: r_shp_v[k] <= 1'b0;
                            endcase
                        end
                    end
                end else begin
                    cout_scm_data    <= cin_scm_data;
                    cout_scm_data_wr <= 1'b1;
                end
            end
        end
    end

endmodule
